// File: rtl/tb_mem_slave_pkg.sv
// Shared types and constants for the simulation memory slave: FSM states,
// memory-mapped I/O addresses, magic values and the wait-LFSR step function.
package tb_mem_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [31:0] ADDR_CONSOLE = 32'h1000_0000;
    localparam logic [31:0] ADDR_PASS    = 32'h2000_0000;
    localparam logic [31:0] PASS_MAGIC   = 32'h075B_CD15;
    localparam logic [31:0] ERR_RDATA    = 32'hDEAD_BEEF;
    localparam logic [15:0] LFSR_SEED    = 16'hACE1;

    // Fibonacci step, taps 16,14,13,11 map to bits 15,13,12,10; shifts left.
    function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
        return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
    endfunction

endpackage

// File: rtl/tb_mem_slave_wait_lfsr.sv
// Free-running 16-bit LFSR used to randomise per-transaction wait cycles.
module wait_lfsr
    import tb_mem_slave_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] value
);

    logic [15:0] lfsr_q;

    // Advance every cycle; an all-zero state is a lock-up, so reseed from it.
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (lfsr_q == 16'h0000) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/tb_mem_slave.sv
// Simulation memory slave for a native valid/ready core bus: SRAM, console
// byte port, pass flag and bus-error detection with configurable wait cycles.
module tb_mem_slave
    import tb_mem_slave_pkg::*;
#(
    parameter int MEM_WORDS = 32768,
    parameter int LATENCY   = 1,
    parameter int RAND_WAIT = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        tests_passed,
    output logic        console_valid,
    output logic [7:0]  console_data,
    output logic        bus_error
);

    localparam int          IDX_W      = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [32:0] SRAM_BYTES = 33'(MEM_WORDS) << 2;
    localparam bit          RAND_EN    = (RAND_WAIT != 32'sd0);

    logic [31:0] sram [MEM_WORDS];

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [31:0] instr_count_q;
    logic        mem_ready_q;
    logic [31:0] mem_rdata_q;
    logic        tests_passed_q;
    logic        console_valid_q;
    logic [7:0]  console_data_q;
    logic        bus_error_q;

    logic [15:0]      lfsr_val;
    logic             unused_lfsr;
    logic [31:0]      acc_addr_d;
    logic [31:0]      acc_wdata_d;
    logic [3:0]       acc_wstrb_d;
    logic [IDX_W-1:0] acc_idx_d;
    logic [4:0]       wait_load_d;
    logic             in_sram_d;
    logic             is_console_d;
    logic             is_pass_d;
    logic [31:0]      rdata_d;
    logic             enter_resp_d;

    wait_lfsr u_lfsr (
        .clock (clock),
        .reset (reset),
        .value (lfsr_val)
    );

    assign unused_lfsr = ^lfsr_val[15:2];

    // Decode the access: live bus inputs while idle (zero-wait case), captured request otherwise.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_addr_d  = mem_addr;
            acc_wdata_d = mem_wdata;
            acc_wstrb_d = mem_wstrb;
        end else begin
            acc_addr_d  = addr_q;
            acc_wdata_d = wdata_q;
            acc_wstrb_d = wstrb_q;
        end
        wait_load_d  = 5'(LATENCY) + (RAND_EN ? {3'b000, lfsr_val[1:0]} : 5'd0);
        acc_idx_d    = acc_addr_d[IDX_W+1:2];
        in_sram_d    = ({1'b0, acc_addr_d} < SRAM_BYTES);
        is_console_d = (acc_addr_d[31:2] == ADDR_CONSOLE[31:2]);
        is_pass_d    = (acc_addr_d[31:2] == ADDR_PASS[31:2]);
        if (in_sram_d) begin
            rdata_d = sram[acc_idx_d];
        end else if (is_console_d || is_pass_d) begin
            rdata_d = 32'h0000_0000;
        end else begin
            rdata_d = ERR_RDATA;
        end
        enter_resp_d = mem_valid &&
                       (((state_q == ST_IDLE) && (wait_load_d == 5'd0)) ||
                        ((state_q == ST_WAIT) && (cnt_q == 5'd1)));
    end

    // Control FSM; all visible outputs are registered on the edge entering RESP.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= 5'd0;
            addr_q          <= 32'h0000_0000;
            wdata_q         <= 32'h0000_0000;
            wstrb_q         <= 4'h0;
            instr_count_q   <= 32'h0000_0000;
            mem_ready_q     <= 1'b0;
            mem_rdata_q     <= 32'h0000_0000;
            tests_passed_q  <= 1'b0;
            console_valid_q <= 1'b0;
            console_data_q  <= 8'h00;
            bus_error_q     <= 1'b0;
        end else begin
            mem_ready_q     <= 1'b0;
            console_valid_q <= 1'b0;
            if (enter_resp_d) begin
                mem_ready_q <= 1'b1;
                mem_rdata_q <= rdata_d;
                if (acc_wstrb_d != 4'h0 && is_console_d) begin
                    console_valid_q <= 1'b1;
                    console_data_q  <= acc_wdata_d[7:0];
                end
                if (acc_wstrb_d != 4'h0 && is_pass_d && acc_wdata_d == PASS_MAGIC) begin
                    tests_passed_q <= 1'b1;
                end
                if (!in_sram_d && !is_console_d && !is_pass_d) begin
                    bus_error_q <= 1'b1;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (mem_valid) begin
                        addr_q  <= mem_addr;
                        wdata_q <= mem_wdata;
                        wstrb_q <= mem_wstrb;
                        cnt_q   <= wait_load_d;
                        state_q <= (wait_load_d == 5'd0) ? ST_RESP : ST_WAIT;
                        if (mem_instr) begin
                            instr_count_q <= instr_count_q + 32'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!mem_valid) begin
                        cnt_q   <= 5'd0;
                        state_q <= ST_IDLE;
                    end else if (cnt_q == 5'd1) begin
                        cnt_q   <= 5'd0;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q   <= cnt_q - 5'd1;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // SRAM lane writes commit at the end of RESP so a reset during the response discards them.
    always_ff @(posedge clock) begin
        if (!reset && state_q == ST_RESP && in_sram_d) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wstrb_d[b]) begin
                    sram[acc_idx_d][8*b +: 8] <= acc_wdata_d[8*b +: 8];
                end
            end
        end
    end

    assign mem_ready     = mem_ready_q;
    assign mem_rdata     = mem_rdata_q;
    assign tests_passed  = tests_passed_q;
    assign console_valid = console_valid_q;
    assign console_data  = console_data_q;
    assign bus_error     = bus_error_q;

endmodule

// File: tb/tb_tb_mem_slave.sv
// Self-checking bench: fixed-latency instance driven from a vector table,
// randomised-wait instance for abort/reset corners and a scoreboarded soak.
module tb_tb_mem_slave;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst0, val0, ins0, rdy0, tp0, cv0, be0;
    logic [31:0] addr0, wd0, rd0;
    logic [3:0]  ws0;
    logic [7:0]  cd0;
    logic        rst1, val1, ins1, rdy1, tp1, cv1, be1;
    logic [31:0] addr1, wd1, rd1;
    logic [3:0]  ws1;
    logic [7:0]  cd1;

    tb_mem_slave #(.MEM_WORDS(32768), .LATENCY(1), .RAND_WAIT(0)) dut0 (
        .clock(clock), .reset(rst0), .mem_valid(val0), .mem_instr(ins0),
        .mem_addr(addr0), .mem_wdata(wd0), .mem_wstrb(ws0), .mem_ready(rdy0),
        .mem_rdata(rd0), .tests_passed(tp0), .console_valid(cv0),
        .console_data(cd0), .bus_error(be0));

    tb_mem_slave #(.MEM_WORDS(1024), .LATENCY(3), .RAND_WAIT(1)) dut1 (
        .clock(clock), .reset(rst1), .mem_valid(val1), .mem_instr(ins1),
        .mem_addr(addr1), .mem_wdata(wd1), .mem_wstrb(ws1), .mem_ready(rdy1),
        .mem_rdata(rd1), .tests_passed(tp1), .console_valid(cv1),
        .console_data(cd1), .bus_error(be1));

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_cv;
        logic [7:0]  exp_cd;
        logic        exp_tp;
        logic        exp_be;
    } vec_t;

    typedef struct {
        logic        chk;
        logic [31:0] rd;
    } sb_t;

    int  n_chk = 0;
    int  n_fail = 0;
    int  rdy1_cnt = 0;
    sb_t sbq[$];

    always @(negedge clock) if (rdy1) rdy1_cnt++;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic v, input logic [31:0] a,
                         input logic [31:0] w, input logic [3:0] s);
        if (which == 0) begin
            val0 = v; addr0 = a; wd0 = w; ws0 = s;
        end else begin
            val1 = v; addr1 = a; wd1 = w; ws1 = s;
        end
    endtask

    task automatic sample(input int which, output logic rdy, output logic [31:0] rd,
                          output logic cv, output logic [7:0] cd, output logic tp, output logic be);
        if (which == 0) begin
            rdy = rdy0; rd = rd0; cv = cv0; cd = cd0; tp = tp0; be = be0;
        end else begin
            rdy = rdy1; rd = rd1; cv = cv1; cd = cd1; tp = tp1; be = be1;
        end
    endtask

    // Issue one request in an idle cycle and hold it until ready; lat counts edges to ready (99 = timeout).
    task automatic txn(input int which, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s,
                       output int lat, output logic [31:0] rd, output logic cv,
                       output logic [7:0] cd, output logic tp, output logic be);
        logic rdy;
        @(posedge clock); #1;
        drive(which, 1'b1, a, w, s);
        lat = 0;
        rdy = 1'b0;
        while (!rdy && lat < 40) begin
            @(posedge clock); #1;
            lat++;
            sample(which, rdy, rd, cv, cd, tp, be);
        end
        drive(which, 1'b0, 32'h0, 32'h0, 4'h0);
        if (!rdy) lat = 99;
    endtask

    task automatic check_reset_vals(input string tag, input int which);
        logic rdy, cv, tp, be;
        logic [31:0] rd;
        logic [7:0] cd;
        sample(which, rdy, rd, cv, cd, tp, be);
        check({tag, "_ready"}, 32'(rdy), 32'd0);
        check({tag, "_rdata"}, rd, 32'd0);
        check({tag, "_cvalid"}, 32'(cv), 32'd0);
        check({tag, "_cdata"}, 32'(cd), 32'd0);
        check({tag, "_passed"}, 32'(tp), 32'd0);
        check({tag, "_buserr"}, 32'(be), 32'd0);
    endtask

    vec_t        vt [18];
    logic [31:0] model [16];
    int          lat, start_cnt, sel, idx;
    logic [31:0] rd, a, w;
    logic [3:0]  s;
    logic        cv, tp, be;
    logic [7:0]  cd;
    sb_t         e;

    initial begin
        //       addr          wdata         strb  chk   exp_rd        cv    cd     tp    be
        vt[0]  = '{32'h0000_0010, 32'h1234_5678, 4'hF, 1'b0, 32'h0,         1'b0, 8'h00, 1'b0, 1'b0};
        vt[1]  = '{32'h0000_0010, 32'h0,         4'h0, 1'b1, 32'h1234_5678, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[2]  = '{32'h0000_0014, 32'h1122_3344, 4'hF, 1'b0, 32'h0,         1'b0, 8'h00, 1'b0, 1'b0};
        vt[3]  = '{32'h0000_0014, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0,         1'b0, 8'h00, 1'b0, 1'b0};
        vt[4]  = '{32'h0000_0014, 32'h0,         4'h0, 1'b1, 32'h11BB_33DD, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[5]  = '{32'h0000_0016, 32'h0,         4'h0, 1'b1, 32'h11BB_33DD, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[6]  = '{32'h1000_0000, 32'h0000_0041, 4'hF, 1'b1, 32'h0,         1'b1, 8'h41, 1'b0, 1'b0};
        vt[7]  = '{32'h1000_0000, 32'h0,         4'h0, 1'b1, 32'h0,         1'b0, 8'h00, 1'b0, 1'b0};
        vt[8]  = '{32'h2000_0000, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0,         1'b0, 8'h00, 1'b0, 1'b0};
        vt[9]  = '{32'h2000_0000, 32'h075B_CD15, 4'h0, 1'b1, 32'h0,         1'b0, 8'h00, 1'b0, 1'b0};
        vt[10] = '{32'h2000_0000, 32'h075B_CD15, 4'hF, 1'b1, 32'h0,         1'b0, 8'h00, 1'b1, 1'b0};
        vt[11] = '{32'h0000_0010, 32'h0,         4'h0, 1'b1, 32'h1234_5678, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[12] = '{32'h0001_FFFC, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0,         1'b0, 8'h00, 1'b1, 1'b0};
        vt[13] = '{32'h0001_FFFC, 32'h0,         4'h0, 1'b1, 32'hCAFE_F00D, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[14] = '{32'h0002_0000, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00, 1'b1, 1'b1};
        vt[15] = '{32'h3000_0000, 32'h0,         4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 8'h00, 1'b1, 1'b1};
        vt[16] = '{32'h0000_0014, 32'h5566_7788, 4'hA, 1'b0, 32'h0,         1'b0, 8'h00, 1'b1, 1'b1};
        vt[17] = '{32'h0000_0014, 32'h0,         4'h0, 1'b1, 32'h55BB_77DD, 1'b0, 8'h00, 1'b1, 1'b1};

        rst0 = 1'b1; rst1 = 1'b1; ins0 = 1'b0; ins1 = 1'b0;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(posedge clock);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        check_reset_vals("reset0", 0);
        check_reset_vals("reset1", 1);
        check("lfsr_seed", 32'(dut1.u_lfsr.value), 32'h0000_ACE1);

        // Table-driven functional vectors on the fixed-latency instance.
        for (int i = 0; i < 18; i++) begin
            sbq.push_back('{vt[i].chk_rd, vt[i].exp_rd});
            txn(0, vt[i].addr, vt[i].wdata, vt[i].wstrb, lat, rd, cv, cd, tp, be);
            e = sbq.pop_front();
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
            if (e.chk) check($sformatf("v%0d_rdata", i), rd, e.rd);
            check($sformatf("v%0d_cvalid", i), 32'(cv), 32'(vt[i].exp_cv));
            if (vt[i].exp_cv) check($sformatf("v%0d_cdata", i), 32'(cd), 32'(vt[i].exp_cd));
            check($sformatf("v%0d_passed", i), 32'(tp), 32'(vt[i].exp_tp));
            check($sformatf("v%0d_buserr", i), 32'(be), 32'(vt[i].exp_be));
        end

        // Console strobe lasts one cycle while the data byte holds.
        txn(0, 32'h1000_0000, 32'h0000_005A, 4'h1, lat, rd, cv, cd, tp, be);
        check("con_pulse", 32'(cv), 32'd1);
        @(posedge clock); #1;
        check("con_pulse_end", 32'(cv0), 32'd0);
        check("con_data_hold", 32'(cd0), 32'h0000_005A);
        check("ready_single", 32'(rdy0), 32'd0);

        // Read data holds after the response cycle.
        txn(0, 32'h0000_0010, 32'h0, 4'h0, lat, rd, cv, cd, tp, be);
        check("hold_rd", rd, 32'h1234_5678);
        repeat (2) @(posedge clock);
        #1;
        check("hold_rd_later", rd0, 32'h1234_5678);

        // Dropping valid during the wait aborts: no ready, no write.
        drive(0, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'hF);
        @(posedge clock); #1;
        check("abort_wait_noready", 32'(rdy0), 32'd0);
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            check($sformatf("abort_noready%0d", k), 32'(rdy0), 32'd0);
        end
        txn(0, 32'h0000_0010, 32'h0, 4'h0, lat, rd, cv, cd, tp, be);
        check("abort_nowrite", rd, 32'h1234_5678);
        check("abort_latency", 32'(lat), 32'd2);
        check("sticky_passed", 32'(tp), 32'd1);
        check("sticky_buserr", 32'(be), 32'd1);

        // Reset clears sticky flags but not memory.
        @(posedge clock); #1;
        rst0 = 1'b1;
        @(posedge clock); #1;
        rst0 = 1'b0;
        check_reset_vals("reset0b", 0);
        txn(0, 32'h0000_0014, 32'h0, 4'h0, lat, rd, cv, cd, tp, be);
        check("mem_after_reset", rd, 32'h55BB_77DD);

        // Random-wait instance: reset in the second WAIT cycle discards the write.
        txn(1, 32'h0000_0040, 32'h0BAD_F00D, 4'hF, lat, rd, cv, cd, tp, be);
        @(posedge clock); #1;
        drive(1, 1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'hF);
        @(posedge clock); #1;
        check("rst_wait1_noready", 32'(rdy1), 32'd0);
        @(posedge clock); #1;
        check("rst_wait2_noready", 32'(rdy1), 32'd0);
        rst1 = 1'b1;
        @(posedge clock); #1;
        rst1 = 1'b0;
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        check_reset_vals("rst_mid", 1);
        for (int k = 0; k < 8; k++) begin
            @(posedge clock); #1;
            check($sformatf("rst_noready%0d", k), 32'(rdy1), 32'd0);
        end
        txn(1, 32'h0000_0040, 32'h0, 4'h0, lat, rd, cv, cd, tp, be);
        check("rst_nowrite", rd, 32'h0BAD_F00D);

        // Preload the soak region, then back-to-back random traffic against the model.
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            txn(1, 32'h0000_0100 + 32'(i) * 32'd4, model[i], 4'hF, lat, rd, cv, cd, tp, be);
        end
        repeat (2) @(negedge clock);
        start_cnt = rdy1_cnt;
        for (int k = 0; k < 1000; k++) begin
            sel  = $urandom_range(0, 9);
            w    = $urandom;
            ins1 = 1'($urandom_range(0, 1));
            if (sel == 0) begin
                a = 32'h0000_1000;
                s = ($urandom_range(0, 1) == 1) ? 4'hF : 4'h0;
                e = '{1'b1, 32'hDEAD_BEEF};
            end else begin
                idx = $urandom_range(0, 15);
                a   = 32'h0000_0100 + 32'(idx) * 32'd4;
                if ($urandom_range(0, 1) == 1) begin
                    s = 4'h0;
                    e = '{1'b1, model[idx]};
                end else begin
                    s = 4'($urandom_range(1, 15));
                    e = '{1'b0, 32'h0};
                    for (int b = 0; b < 4; b++) if (s[b]) model[idx][8*b +: 8] = w[8*b +: 8];
                end
            end
            sbq.push_back(e);
            txn(1, a, w, s, lat, rd, cv, cd, tp, be);
            e = sbq.pop_front();
            n_chk++;
            if (lat < 4 || lat > 7) begin
                n_fail++;
                $display("FAIL rnd%0d_latency: got %0d expected 4..7", k, lat);
            end
            if (e.chk) check($sformatf("rnd%0d_rdata", k), rd, e.rd);
        end
        repeat (3) @(negedge clock);
        check("rnd_ready_count", 32'(rdy1_cnt - start_cnt), 32'd1000);
        check("rnd_queue_empty", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/tb_mem_slave.md
TB_MEM_SLAVE -- requirements
Module: tb_mem_slave

Interface
REQ-001 Parameter MEM_WORDS, default 32768, SRAM depth in 32-bit words (128 KiB).
REQ-002 Parameter LATENCY, default 1, fixed wait cycles from request capture to mem_ready (range 0..15).
REQ-003 Parameter RAND_WAIT, default 0, when 1 adds LFSR[1:0] (0..3) extra wait cycles per transaction.
REQ-004 clock  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 mem_valid  input  1  core request valid, held until mem_ready.
REQ-007 mem_instr  input  1  request is instruction fetch (no effect on function; counted only).
REQ-008 mem_addr  input  32  byte address; bits [1:0] ignored.
REQ-009 mem_wdata  input  32  write data.
REQ-010 mem_wstrb  input  4  byte write enables; 0000 = read.
REQ-011 mem_ready  output  1  single-cycle completion pulse.
REQ-012 mem_rdata  output  32  read data, valid when mem_ready=1.
REQ-013 tests_passed  output  1  sticky pass flag.
REQ-014 console_valid  output  1  one-cycle pulse, console byte written.
REQ-015 console_data  output  8  console byte, valid with console_valid.
REQ-016 bus_error  output  1  sticky flag, access to unmapped address.

Function
REQ-017 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-018 IDLE with mem_valid=1: capture addr/wdata/wstrb, load wait counter with LATENCY (+LFSR[1:0] if RAND_WAIT), go WAIT; if load value is 0 go RESP directly.
REQ-019 WAIT: decrement counter each cycle; counter reaching 0 transitions to RESP next cycle.
REQ-020 RESP: mem_ready=1 for exactly one cycle, perform access, return to IDLE; total latency = 1 + wait cycles after mem_valid first seen.
REQ-021 Request issued the cycle after RESP is a new transaction (back-to-back supported, no bubble beyond IDLE capture).
REQ-022 mem_valid dropping in WAIT: abort to IDLE, no write, no ready, no flag changes.
REQ-023 SRAM region: mem_addr < MEM_WORDS*4; word index mem_addr[31:2]; write updates only lanes with wstrb bit set; read returns full stored word.
REQ-024 Write to 0x1000_0000: console_valid=1, console_data=wdata[7:0] in RESP cycle; read returns 0.
REQ-025 Write to 0x2000_0000 with wdata=123456789 (0x075B_CD15): tests_passed set; other values or reads: no change, read returns 0.
REQ-026 Any other address: bus_error set, mem_ready still pulsed, mem_rdata=0xDEAD_BEEF.
REQ-027 mem_rdata holds last value outside RESP; 0 after reset.
REQ-028 LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every cycle, never all-zero.

Reset
REQ-029 Reset: state IDLE, counter 0, mem_ready 0, mem_rdata 0, console_valid 0, console_data 0, tests_passed 0, bus_error 0, LFSR 0xACE1.
REQ-030 Reset mid-transaction (WAIT/RESP): transaction discarded, no ready pulse, no write, next cycle IDLE.
REQ-031 SRAM array (named sram) is not reset; loaded externally via $readmemh on hierarchical path.

Structure
REQ-032 Shared package holds FSM state enum, ADDR_CONSOLE, ADDR_PASS, PASS_MAGIC, ERR_RDATA, LFSR seed.
REQ-033 One sub-module wait_lfsr (16-bit LFSR, clock/reset, value output); rest in tb_mem_slave.
REQ-034 Drop-in replacement for the current testbench memory: same port names for the core-facing signals and tests_passed.

Verification
REQ-035 LATENCY=1, RAND_WAIT=0, read 0x0000_0010 preloaded 0x1234_5678 -> mem_ready 2 cycles after valid, mem_rdata=0x1234_5678.
REQ-036 Write 0xAABB_CCDD wstrb=0101 to word holding 0x1122_3344, read back -> 0x11BB_33DD.
REQ-037 Write 0x0000_0041 to 0x1000_0000 -> console_valid one cycle, console_data=0x41; write 123456789 to 0x2000_0000 -> tests_passed=1 and stays 1.
REQ-038 Read 0x3000_0000 -> mem_ready pulse, mem_rdata=0xDEAD_BEEF, bus_error=1 sticky.
REQ-039 LATENCY=3, assert reset in 2nd WAIT cycle -> no mem_ready, target word unchanged, all outputs at reset values.
REQ-040 RAND_WAIT=1, 1000 random back-to-back accesses vs scoreboard -> data matches, every latency in 1+LATENCY..4+LATENCY, exactly one ready per request.
